// File: rtl/data_mem_ctrl.sv
// Memory-access stage: turns ALU address + store data into a req/ack RAM access,
// stalling the single-cycle core until the access completes, times out or is dropped.
module data_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       y,
    input  logic [31:0]       rd2,
    output logic [31:0]       readdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              align_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Handshake: mem_req rises at issue and stays high, with address/we/wdata
    // stable, until the cycle after mem_ack is sampled high (or the access times out).
    state_t            state_q, state_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              align_err_q, align_err_d;
    logic              bus_err_q, bus_err_d;

    logic acc;
    logic aligned;

    assign acc     = memread | memwrite;
    assign aligned = (y[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        readdata_d  = readdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        align_err_d = 1'b0;
        bus_err_d   = bus_err_q;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                stall = acc & aligned;
                if (acc && aligned) begin
                    // memwrite alone decides direction, so read+write becomes a store
                    mem_addr_d  = y[ADDR_W+1:2];
                    mem_wdata_d = rd2;
                    mem_we_d    = memwrite;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end else if (acc) begin
                    align_err_d = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) readdata_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) readdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            readdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            readdata_q  <= readdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign readdata  = readdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign align_err = align_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-access stage directly downstream of the datapath ALU.
- Consumes the ALU result (y) as the byte address and register-file read port 2 (rd2) as store data.
- Drives a request/acknowledge handshake to an external word-wide data RAM and returns readdata for the write-back mux.
- Asserts stall so the PC and register file hold while an access is outstanding, which lets the single-cycle core tolerate multi-cycle memory.

Parameters:
ADDR_W, 10, word-address width presented to the RAM (RAM depth = 2**ADDR_W words)
TIMEOUT, 16, max BUSY cycles without mem_ack before the access is aborted (>=2)

Ports:
clk  input  1  global system clock, rising edge
reset  input  1  system reset, asynchronous, active-high
memread  input  1  load request from the controller (lw)
memwrite  input  1  store request from the controller (sw)
y  input  32  ALU result = byte address
rd2  input  32  store data
readdata  output  32  load data to the write-back mux, registered
stall  output  1  hold PC/regfile writes this cycle
mem_req  output  1  RAM request, registered
mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  output  ADDR_W  word address = y[ADDR_W+1:2], registered at issue
mem_wdata  output  32  store data, registered at issue
mem_ack  input  1  RAM completion; one-cycle pulse
mem_rdata  input  32  RAM read data, valid with mem_ack
align_err  output  1  one-cycle pulse: misaligned access dropped
bus_err  output  1  sticky: an access timed out; cleared only by reset

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE
  - readdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - timeout counter = 0, align_err = 0, bus_err = 0
- Access request: acc = memread | memwrite.
- Write priority: memread and memwrite both high is treated as a write; readdata is not updated.
- Misaligned access (acc and y[1:0] != 0):
  - Never issued.
  - align_err pulses for the next cycle.
  - stall = 0 (the instruction retires as a no-op).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = acc & aligned (combinational).
  - On an aligned acc: latch mem_addr, mem_wdata (= rd2) and mem_we (= memwrite); set mem_req = 1; clear the counter; go to BUSY.
  - A mem_ack arriving in IDLE is ignored.
- BUSY:
  - stall = 1; mem_req, mem_addr, mem_we and mem_wdata held stable.
  - Counter increments each cycle.
  - On mem_ack: mem_req <= 0; on a read, readdata <= mem_rdata; go to DONE.
  - If the counter reaches TIMEOUT-1 without mem_ack: mem_req <= 0; bus_err <= 1; on a read, readdata <= 0; go to DONE.
  - If mem_ack and timeout coincide, the ack wins and bus_err is not set.
- DONE:
  - stall = 0, so the datapath commits (a load writes readdata) on this edge.
  - Next state is always IDLE; no new access is accepted in DONE.
- Latency:
  - A load with zero-wait ack (ack in the first BUSY cycle) stalls 2 cycles; readdata is valid in cycle 2 (DONE).
  - Each RAM wait state adds 1 stall cycle.
- readdata holds its value between loads.
- Input hold: y and rd2 may change while BUSY (the datapath is stalled but not required to hold them); the latched values are used.
- Reset mid-access: mem_req drops asynchronously and the state returns to IDLE. A late mem_ack is then ignored. The RAM must tolerate an abandoned request.
- Address wrap: bits of y above ADDR_W+1 are ignored, so addresses alias modulo 2**(ADDR_W+2).
- No memory access (acc = 0): stall = 0; all outputs hold, except align_err = 0.

Test Plan:
1. Reset state: assert reset mid-cycle with no clock -> all outputs 0 immediately. Deassert, then memread = 1, y = 0x10, ack in the first BUSY cycle with mem_rdata = 0xCAFEF00D -> mem_addr = 4, mem_we = 0, stall high for 2 cycles, readdata = 0xCAFEF00D in DONE.
2. Store with 3 wait states: memwrite = 1, y = 0x24, rd2 = 0x12345678, ack on the 4th BUSY cycle -> mem_we = 1, mem_addr = 9, mem_wdata = 0x12345678 stable throughout, stall high for 5 cycles, readdata unchanged.
3. Timeout: TIMEOUT = 16, memread = 1, y = 0x8, no ack -> mem_req drops after 16 BUSY cycles, bus_err = 1 and stays 1, readdata = 0, stall falls in DONE. A later successful load leaves bus_err = 1.
4. Misaligned: memread = 1, y = 0x13 -> mem_req stays 0, stall = 0, align_err pulses one cycle. Both memread and memwrite high at y = 0x20 -> mem_we = 1.
5. Reset during BUSY: issue a load, assert reset on the 2nd BUSY cycle -> mem_req = 0 immediately, state IDLE. mem_ack pulsed after reset release -> readdata stays 0, no state change.
6. Back-to-back loads: y = 0x0 then y = 0x4, each with a zero-wait ack -> each takes 3 cycles (IDLE, BUSY, DONE); the second mem_req asserts exactly one cycle after DONE; each readdata returns the correct word.
